// File: rtl/ex_stage.sv
// ex_stage: execute stage with one-hot ALU, single-cycle multiplier and a 32-step restoring divider.
module ex_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ID_valid,
    input  logic [153:0] IDreg_bus,
    input  logic         ID_ready_go,
    input  logic         MEM_allow_in,
    output logic         EX_allow_in,
    output logic         EX_ready_go,
    output logic         EXreg_valid,
    output logic [107:0] EXreg_bus,
    output logic         EX_fwd_we,
    output logic [4:0]   EX_fwd_addr,
    output logic [31:0]  EX_fwd_data,
    output logic         EX_fwd_stall
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
    div_state_t   state;
    logic         ex_valid;
    logic [153:0] bus_r;
    logic [4:0]   cnt;
    logic [31:0]  quo, rem, dvs;
    logic [11:0]  alu_op;
    logic [31:0]  src1, src2, rkd_value, pc;
    logic         mul, div, mem_en, rf_we, res_from_mem;
    logic [3:0]   mem_we;
    logic [4:0]   rf_waddr, sh;
    logic [31:0]  alu_res, sra_res, mul_res, div_res, ex_result;
    logic [31:0]  abs1, abs2, q_fix, r_fix;
    logic [63:0]  prod;
    logic [32:0]  trial, diff;
    logic         signed_op;

    assign {alu_op, src1, src2, mul, div, rkd_value, mem_en, mem_we, rf_we, res_from_mem, rf_waddr, pc} = bus_r;

    assign EX_ready_go  = ~div | (state == DONE);
    assign EX_allow_in  = ~ex_valid | (EX_ready_go & MEM_allow_in);
    assign EXreg_valid  = ex_valid & EX_ready_go;
    assign EX_fwd_we    = ex_valid & rf_we;
    assign EX_fwd_addr  = rf_waddr;
    assign EX_fwd_data  = ex_result;
    assign EX_fwd_stall = ex_valid & (res_from_mem | ~EX_ready_go);
    assign EXreg_bus    = {ex_result, rkd_value, mem_en, mem_we, rf_we, res_from_mem, rf_waddr, pc};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_valid <= 1'b0;
            bus_r    <= '0;
        end else if (EX_allow_in & ID_ready_go) begin
            ex_valid <= ID_valid;
            bus_r    <= IDreg_bus;
        end else if (EX_ready_go & MEM_allow_in) begin
            ex_valid <= 1'b0;
        end
    end

    assign sh      = src2[4:0];
    assign sra_res = $signed(src1) >>> sh;
    assign alu_res = ({32{alu_op[0]}}  & (src1 + src2))
                   | ({32{alu_op[1]}}  & (src1 - src2))
                   | ({32{alu_op[2]}}  & {31'd0, $signed(src1) < $signed(src2)})
                   | ({32{alu_op[3]}}  & {31'd0, src1 < src2})
                   | ({32{alu_op[4]}}  & (src1 & src2))
                   | ({32{alu_op[5]}}  & ~(src1 | src2))
                   | ({32{alu_op[6]}}  & (src1 | src2))
                   | ({32{alu_op[7]}}  & (src1 ^ src2))
                   | ({32{alu_op[8]}}  & (src1 << sh))
                   | ({32{alu_op[9]}}  & (src1 >> sh))
                   | ({32{alu_op[10]}} & sra_res)
                   | ({32{alu_op[11]}} & src2);

    // Low word is identical for signed and unsigned, so only mulh.w sign-extends.
    assign prod    = {{32{alu_op[1] & src1[31]}}, src1} * {{32{alu_op[1] & src2[31]}}, src2};
    assign mul_res = alu_op[0] ? prod[31:0] : prod[63:32];

    assign signed_op = alu_op[0] | alu_op[2];
    assign abs1      = (signed_op & src1[31]) ? -src1 : src1;
    assign abs2      = (signed_op & src2[31]) ? -src2 : src2;
    assign trial     = {rem, quo[31]};
    assign diff      = trial - {1'b0, dvs};
    assign q_fix     = (src2 == 32'd0) ? 32'hFFFF_FFFF : (signed_op & (src1[31] ^ src2[31])) ? -quo : quo;
    assign r_fix     = (signed_op & src1[31]) ? -rem : rem;
    assign div_res   = (alu_op[0] | alu_op[1]) ? q_fix : r_fix;

    assign ex_result = div ? div_res : mul ? mul_res : alu_res;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
        end else begin
            case (state)
                IDLE: if (ex_valid & div) begin
                    state <= BUSY;
                    cnt   <= '0;
                    quo   <= abs1;
                    rem   <= '0;
                    dvs   <= abs2;
                end
                BUSY: begin
                    quo   <= {quo[30:0], ~diff[32]};
                    rem   <= diff[32] ? trial[31:0] : diff[31:0];
                    cnt   <= cnt + 5'd1;
                    state <= (cnt == 5'd31) ? DONE : BUSY;
                end
                DONE: if (MEM_allow_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vector bench for ex_stage (ALU/MUL table, divider sequences, reset).
module tb_ex_stage;
    logic         clk = 1'b0, resetn = 1'b0;
    logic         ID_valid = 1'b0, ID_ready_go = 1'b0, MEM_allow_in = 1'b0;
    logic [153:0] IDreg_bus = '0;
    logic         EX_allow_in, EX_ready_go, EXreg_valid, EX_fwd_we, EX_fwd_stall;
    logic [107:0] EXreg_bus;
    logic [4:0]   EX_fwd_addr;
    logic [31:0]  EX_fwd_data;
    int           checks = 0, failures = 0;

    typedef struct {
        string       nm;
        logic [11:0] op;
        logic        mul;
        logic [31:0] a, b, r;
    } vec_t;

    vec_t alu_v[19];
    vec_t div_v[10];

    ex_stage dut (
        .clk(clk), .resetn(resetn), .ID_valid(ID_valid), .IDreg_bus(IDreg_bus),
        .ID_ready_go(ID_ready_go), .MEM_allow_in(MEM_allow_in), .EX_allow_in(EX_allow_in),
        .EX_ready_go(EX_ready_go), .EXreg_valid(EXreg_valid), .EXreg_bus(EXreg_bus),
        .EX_fwd_we(EX_fwd_we), .EX_fwd_addr(EX_fwd_addr), .EX_fwd_data(EX_fwd_data),
        .EX_fwd_stall(EX_fwd_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [107:0] act, input logic [107:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [153:0] make_bus(input logic [11:0] op, input logic m, input logic d,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic rfm, input logic [4:0] wa, input logic [31:0] pc);
        return {op, a, b, m, d, 32'h0000_00AA, 1'b1, 4'hF, 1'b1, rfm, wa, pc};
    endfunction

    function automatic logic [107:0] exp_bus(input logic [31:0] r, input logic rfm,
                                             input logic [4:0] wa, input logic [31:0] pc);
        return {r, 32'h0000_00AA, 1'b1, 4'hF, 1'b1, rfm, wa, pc};
    endfunction

    task automatic issue(input logic [11:0] op, input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic rfm, input logic [4:0] wa, input logic [31:0] pc);
        IDreg_bus   = make_bus(op, m, d, a, b, rfm, wa, pc);
        ID_valid    = 1'b1;
        ID_ready_go = 1'b1;
        @(posedge clk); #1;
        ID_valid = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int   cyc = 0;
        logic bad = 1'b0;
        while (!EX_ready_go && cyc < 100) begin
            bad = bad | EX_allow_in | EXreg_valid;
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, " latency"}, cyc, 33);
        chk({nm, " allow_in low while busy"}, bad, 0);
    endtask

    task automatic run_div(input string nm, input logic [11:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] r);
        issue(op, 1'b0, 1'b1, a, b, 1'b0, 5'd9, 32'h2000);
        chk({nm, " stall"}, EX_fwd_stall, 1);
        wait_ready(nm);
        chk({nm, " result"}, EXreg_bus, exp_bus(r, 1'b0, 5'd9, 32'h2000));
        chk({nm, " valid"}, EXreg_valid, 1);
        @(posedge clk); #1;
        chk({nm, " drained"}, EX_allow_in, 1);
    endtask

    initial begin
        logic stable;
        int   xfers;
        alu_v[0]  = '{"add",       12'h001, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        alu_v[1]  = '{"sub",       12'h002, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
        alu_v[2]  = '{"slt",       12'h004, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        alu_v[3]  = '{"sltu",      12'h008, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        alu_v[4]  = '{"and",       12'h010, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        alu_v[5]  = '{"nor",       12'h020, 1'b0, 32'h0F0F_0000, 32'h00FF_0000, 32'hF000_FFFF};
        alu_v[6]  = '{"or",        12'h040, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
        alu_v[7]  = '{"xor",       12'h080, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
        alu_v[8]  = '{"sll",       12'h100, 1'b0, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
        alu_v[9]  = '{"srl",       12'h200, 1'b0, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
        alu_v[10] = '{"sra",       12'h400, 1'b0, 32'h8000_0010, 32'h0000_0024, 32'hF800_0001};
        alu_v[11] = '{"lui",       12'h800, 1'b0, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000};
        alu_v[12] = '{"mul.w",     12'h001, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        alu_v[13] = '{"mulh.w",    12'h002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        alu_v[14] = '{"mulh.wu",   12'h004, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        alu_v[15] = '{"mulh.w neg",12'h002, 1'b1, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
        alu_v[16] = '{"mul.w 2",   12'h001, 1'b1, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
        alu_v[17] = '{"sra pos",   12'h400, 1'b0, 32'h4000_0000, 32'h0000_001F, 32'h0000_0000};
        alu_v[18] = '{"srl 4",     12'h200, 1'b0, 32'h8000_0010, 32'h0000_0004, 32'h0800_0001};
        div_v[0]  = '{"div.w -7/2",   12'h001, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        div_v[1]  = '{"mod.w -7/2",   12'h004, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        div_v[2]  = '{"div.wu 5/0",   12'h002, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
        div_v[3]  = '{"mod.wu 5/0",   12'h008, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
        div_v[4]  = '{"div.w 100/-7", 12'h001, 1'b0, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2};
        div_v[5]  = '{"mod.w 100/-7", 12'h004, 1'b0, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002};
        div_v[6]  = '{"div.wu max/3", 12'h002, 1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 32'h5555_5555};
        div_v[7]  = '{"mod.w -7/0",   12'h004, 1'b0, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9};
        div_v[8]  = '{"div.w min/0",  12'h001, 1'b0, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        div_v[9]  = '{"div.w min/-1", 12'h001, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};

        #22;
        chk("reset allow_in", EX_allow_in, 1);
        chk("reset ready_go", EX_ready_go, 1);
        chk("reset reg_valid", EXreg_valid, 0);
        chk("reset fwd_we", EX_fwd_we, 0);
        chk("reset fwd_stall", EX_fwd_stall, 0);
        chk("reset fwd_data", EX_fwd_data, 0);
        @(posedge clk); #1;
        resetn       = 1'b1;
        MEM_allow_in = 1'b1;

        for (int i = 0; i < 19; i++) begin
            issue(alu_v[i].op, alu_v[i].mul, 1'b0, alu_v[i].a, alu_v[i].b, 1'b0, 5'(i + 1), 32'(32'h100 + 4 * i));
            chk({alu_v[i].nm, " bus"}, EXreg_bus, exp_bus(alu_v[i].r, 1'b0, 5'(i + 1), 32'(32'h100 + 4 * i)));
            chk({alu_v[i].nm, " valid"}, EXreg_valid, 1);
            chk({alu_v[i].nm, " fwd"}, {EX_fwd_we, EX_fwd_addr, EX_fwd_stall}, {1'b1, 5'(i + 1), 1'b0});
        end

        IDreg_bus   = make_bus(12'h001, 1'b0, 1'b0, 32'd1, 32'd1, 1'b0, 5'd1, 32'h0);
        ID_valid    = 1'b1;
        ID_ready_go = 1'b0;
        @(posedge clk); #1;
        chk("id not ready no load", EXreg_valid, 0);
        ID_valid    = 1'b0;
        ID_ready_go = 1'b1;

        issue(12'h001, 1'b0, 1'b0, 32'd8, 32'd4, 1'b1, 5'd4, 32'h300);
        chk("load stall", EX_fwd_stall, 1);
        chk("load bus", EXreg_bus, exp_bus(32'd12, 1'b1, 5'd4, 32'h300));

        for (int i = 0; i < 10; i++)
            run_div(div_v[i].nm, div_v[i].op, div_v[i].a, div_v[i].b, div_v[i].r);

        issue(12'h001, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 5'd5, 32'h400);
        IDreg_bus = make_bus(12'h008, 1'b0, 1'b1, 32'd100, 32'd7, 1'b0, 5'd6, 32'h404);
        ID_valid  = 1'b1;
        wait_ready("b2b first");
        chk("b2b first result", EXreg_bus, exp_bus(32'hFFFF_FFFD, 1'b0, 5'd5, 32'h400));
        @(posedge clk); #1;
        ID_valid = 1'b0;
        chk("b2b second entry", EXreg_valid, 0);
        wait_ready("b2b second");
        chk("b2b second result", EXreg_bus, exp_bus(32'd2, 1'b0, 5'd6, 32'h404));
        @(posedge clk); #1;

        MEM_allow_in = 1'b0;
        issue(12'h002, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, 1'b0, 5'd7, 32'h500);
        wait_ready("hold");
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            stable = stable & (EX_fwd_data == 32'h5555_5555) & EXreg_valid & EX_ready_go & ~EX_allow_in;
        end
        chk("hold stable", stable, 1);
        MEM_allow_in = 1'b1;
        @(posedge clk); #1;
        chk("hold released", EX_allow_in, 1);
        xfers = 0;
        repeat (5) begin
            @(posedge clk); #1;
            xfers += int'(EXreg_valid);
        end
        chk("hold single transfer", xfers, 0);

        issue(12'h001, 1'b0, 1'b1, 32'd1000, 32'd3, 1'b0, 5'd8, 32'h600);
        repeat (16) begin
            @(posedge clk); #1;
        end
        #2;
        resetn = 1'b0;
        #1;
        chk("async reset allow_in", EX_allow_in, 1);
        chk("async reset ready_go", EX_ready_go, 1);
        chk("async reset stall", EX_fwd_stall, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        issue(12'h001, 1'b0, 1'b0, 32'd2, 32'd3, 1'b0, 5'd10, 32'h700);
        chk("post reset add", EXreg_bus, exp_bus(32'd5, 1'b0, 5'd10, 32'h700));
        chk("post reset valid", EXreg_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: EX_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port ID_valid, input, 1 bit: ID output valid.
REQ-004 SHALL have port IDreg_bus, input, 154 bits, MSB to LSB: alu_op[11:0], src1[31:0], src2[31:0], mul, div, rkd_value[31:0], mem_en, mem_we[3:0], rf_we, res_from_mem, rf_waddr[4:0], pc[31:0].
REQ-005 SHALL have port ID_ready_go, input, 1 bit: ID can hand off.
REQ-006 SHALL have port MEM_allow_in, input, 1 bit: MEM accepts this cycle.
REQ-007 SHALL have port EX_allow_in, output, 1 bit: EX accepts from ID.
REQ-008 SHALL have port EX_ready_go, output, 1 bit: EX result complete.
REQ-009 SHALL have port EXreg_valid, output, 1 bit: EX_valid & EX_ready_go.
REQ-010 SHALL have port EXreg_bus, output, 108 bits, MSB to LSB: ex_result[31:0], rkd_value, mem_en, mem_we, rf_we, res_from_mem, rf_waddr, pc.
REQ-011 SHALL have port EX_fwd_we, output, 1 bit: EX_valid & rf_we.
REQ-012 SHALL have port EX_fwd_addr, output, 5 bits: latched rf_waddr.
REQ-013 SHALL have port EX_fwd_data, output, 32 bits: ex_result.
REQ-014 SHALL have port EX_fwd_stall, output, 1 bit: EX_valid & (res_from_mem | ~EX_ready_go); ID pauses on match.

Function
REQ-015 Pipeline register SHALL load IDreg_bus, and EX_valid SHALL load ID_valid, when EX_allow_in & ID_ready_go.
REQ-016 Otherwise, if EX_ready_go & MEM_allow_in, EX_valid SHALL clear; else EX_valid and the register SHALL hold.
REQ-017 EX_allow_in SHALL be ~EX_valid | (EX_ready_go & MEM_allow_in).
REQ-018 With mul=div=0: one-hot alu_op bits 0..11 SHALL select add, sub, slt (signed), sltu, and, nor, or, xor, sll, srl, sra, lui (result=src2).
REQ-019 Shift amount SHALL be src2[4:0]; add/sub SHALL wrap modulo 2^32.
REQ-020 With mul=1, single-cycle: alu_op[0] SHALL give mul.w (low 32 bits), [1] mulh.w (signed high 32), [2] mulh.wu (unsigned high 32).
REQ-021 With div=1: alu_op[0] SHALL give div.w, [1] div.wu, [2] mod.w, [3] mod.wu.
REQ-022 Signed quotient SHALL truncate toward zero; remainder SHALL take the dividend's sign.
REQ-023 Divider FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-024 IDLE->BUSY when EX_valid & div; operand magnitudes latched; 5-bit counter cleared.
REQ-025 BUSY: one restoring-division step per cycle; ->DONE after exactly 32 BUSY cycles.
REQ-026 DONE: sign-corrected quotient/remainder held; DONE->IDLE when MEM_allow_in.
REQ-027 EX_ready_go SHALL be ~div | (state==DONE); with entry cycle = 0, a div SHALL first assert ready in cycle 33.
REQ-028 Divisor zero SHALL take the same 33-cycle latency, giving quotient 0xFFFFFFFF and remainder = dividend for all four ops.
REQ-029 Back-to-back divs: the second SHALL start in its own entry cycle (FSM in IDLE) with no extra bubble.
REQ-030 A div held in DONE while MEM_allow_in=0 SHALL keep its result stable and SHALL NOT restart.

Reset
REQ-031 On resetn=0, EX_valid=0, FSM=IDLE, counter=0, pipeline register=0, immediately and independently of clk.
REQ-032 Consequently in reset EX_allow_in=1, EX_ready_go=1, EXreg_valid=0, EX_fwd_we=0, EX_fwd_stall=0, EX_fwd_data=0.
REQ-033 Reset during BUSY SHALL abort the division; the first instruction after release SHALL complete normally.

Verification
REQ-034 Scenario: add, src1=0x7FFFFFFF, src2=1, MEM_allow_in=1 -> ex_result=0x80000000, EXreg_valid the cycle after entry.
REQ-035 Scenario: sra, src1=0x80000010, src2=0x24 -> result 0xF8000001; mulh.w 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; mulh.wu -> 0xFFFFFFFE.
REQ-036 Scenario: div.w -7/2 -> 0xFFFFFFFD, ready at cycle 33, EX_allow_in=0 during cycles 0-32; mod.w -7/2 -> 0xFFFFFFFF.
REQ-037 Scenario: div.wu 5/0 -> 0xFFFFFFFF; mod.wu 5/0 -> 5; each with 33-cycle latency.
REQ-038 Scenario: MEM_allow_in=0 for 10 cycles at DONE -> result stable, FSM stays DONE; then one transfer only.
REQ-039 Scenario: resetn low at BUSY cycle 15 -> EX_valid=0 asynchronously; a following add completes in 1 cycle.
